// File: rtl/cell_draw_scheduler_if.sv
// Write-path and renderer-handshake signals between game logic, the scheduler and the cell renderer.
interface cell_draw_scheduler_if;
    logic       wr_en;
    logic [3:0] wr_row;
    logic [3:0] wr_col;
    logic [3:0] wr_data;
    logic       wr_ack;
    logic       wr_err;
    logic       full_redraw;
    logic       draw_start;
    logic [3:0] draw_row;
    logic [3:0] draw_col;
    logic [3:0] draw_data;
    logic       draw_done;
    logic       busy;
    logic [6:0] dirty_count;

    modport master (
        output wr_en, wr_row, wr_col, wr_data, full_redraw, draw_done,
        input  wr_ack, wr_err, draw_start, draw_row, draw_col, draw_data, busy, dirty_count
    );

    modport slave (
        input  wr_en, wr_row, wr_col, wr_data, full_redraw, draw_done,
        output wr_ack, wr_err, draw_start, draw_row, draw_col, draw_data, busy, dirty_count
    );
endinterface

// File: rtl/cell_draw_scheduler.sv
// Board storage plus dirty mask; scans the mask and issues one cell draw at a time to the renderer.
module cell_draw_scheduler #(
    parameter int BOARD_N = 9
) (
    input logic                  clk,
    input logic                  rst,
    cell_draw_scheduler_if.slave bus
);
    localparam int         C      = BOARD_N * BOARD_N;
    localparam int         IW     = $clog2(C);
    localparam logic [3:0] N_LIM  = 4'(BOARD_N);
    localparam logic [3:0] N_LAST = 4'(BOARD_N - 1);
    localparam logic [6:0] C_CNT  = 7'(C);

    typedef enum logic [1:0] {SCAN, ISSUE, WAIT} state_t;
    state_t state, state_nxt;

    logic [C-1:0][3:0] cells;
    logic [C-1:0]      dirty;
    logic [3:0]        ptr_row, ptr_col;
    logic [IW-1:0]     ptr_idx, wr_idx;
    logic              wr_ok, hit, adv, inc, dec;
    logic [6:0]        count;
    logic [3:0]        draw_row, draw_col, draw_data;
    logic              wr_ack, wr_err;

    function automatic logic [IW-1:0] cell_idx(input logic [3:0] r, input logic [3:0] c);
        return IW'(32'(r) * BOARD_N + 32'(c));
    endfunction

    assign ptr_idx = cell_idx(ptr_row, ptr_col);
    assign wr_idx  = cell_idx(bus.wr_row, bus.wr_col);
    assign wr_ok   = bus.wr_en && (bus.wr_row < N_LIM) && (bus.wr_col < N_LIM) && (bus.wr_data <= 4'd9);

    // A write landing on the cell being cleared keeps it dirty, so neither count step applies.
    assign inc = wr_ok && !dirty[wr_idx];
    assign dec = hit && !(wr_ok && (wr_idx == ptr_idx));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= SCAN;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        hit       = 1'b0;
        adv       = 1'b0;
        case (state)
            SCAN: begin
                if (dirty[ptr_idx]) begin
                    hit       = 1'b1;
                    state_nxt = ISSUE;
                end else begin
                    adv = 1'b1;
                end
            end
            ISSUE: begin
                if (bus.draw_done) begin
                    adv       = 1'b1;
                    state_nxt = SCAN;
                end else begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (bus.draw_done) begin
                    adv       = 1'b1;
                    state_nxt = SCAN;
                end
            end
            default: state_nxt = SCAN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cells     <= '0;
            dirty     <= '1;
            count     <= C_CNT;
            ptr_row   <= '0;
            ptr_col   <= '0;
            draw_row  <= '0;
            draw_col  <= '0;
            draw_data <= '0;
            wr_ack    <= 1'b0;
            wr_err    <= 1'b0;
        end else begin
            wr_ack <= wr_ok;
            wr_err <= bus.wr_en && !wr_ok;
            if (adv) begin
                if (ptr_col == N_LAST) begin
                    ptr_col <= '0;
                    ptr_row <= (ptr_row == N_LAST) ? 4'd0 : ptr_row + 4'd1;
                end else begin
                    ptr_col <= ptr_col + 4'd1;
                end
            end
            if (hit) begin
                draw_row       <= ptr_row;
                draw_col       <= ptr_col;
                draw_data      <= cells[ptr_idx];
                dirty[ptr_idx] <= 1'b0;
            end
            // Sets are ordered after the clear so they win on the same cell.
            if (wr_ok) begin
                cells[wr_idx] <= bus.wr_data;
                dirty[wr_idx] <= 1'b1;
            end
            if (bus.full_redraw) begin
                dirty <= '1;
                count <= C_CNT;
            end else begin
                count <= count + 7'(inc) - 7'(dec);
            end
        end
    end

    assign bus.draw_start  = (state == ISSUE);
    assign bus.busy        = (state != SCAN);
    assign bus.draw_row    = draw_row;
    assign bus.draw_col    = draw_col;
    assign bus.draw_data   = draw_data;
    assign bus.wr_ack      = wr_ack;
    assign bus.wr_err      = wr_err;
    assign bus.dirty_count = count;
endmodule

// File: tb/tb_cell_draw_scheduler.sv
// Bench for cell_draw_scheduler: directed scenarios plus random traffic against a cycle-level board model.
module tb_cell_draw_scheduler;
    localparam int N = 9;
    localparam int C = N * N;

    typedef struct { int r; int c; int d; } draw_t;
    typedef struct { logic [3:0] row; logic [3:0] col; logic [3:0] data; bit ack; bit err; } wvec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cell_draw_scheduler_if bus ();
    cell_draw_scheduler #(.BOARD_N(N)) dut (.clk(clk), .rst(rst), .bus(bus));

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // Reference board: plain arrays, a pointer, and whether a draw is outstanding.
    int  m_cell[C];
    bit  m_dirty[C];
    int  m_ptr, m_since, m_row, m_col, m_data;
    bit  m_out, m_start, m_ack, m_err;
    int  rend_lat;
    bit  rand_done;
    draw_t drawq[$];

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    function automatic int popcount();
        int n = 0;
        for (int i = 0; i < C; i++) n += int'(m_dirty[i]);
        return n;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < C; i++) begin
            m_cell[i]  = 0;
            m_dirty[i] = 1'b1;
        end
        m_ptr = 0; m_since = 0; m_row = 0; m_col = 0; m_data = 0;
        m_out = 1'b0; m_start = 1'b0; m_ack = 1'b0; m_err = 1'b0;
    endtask

    task automatic check_outputs(input string tag);
        check($sformatf("%s flags(ack,err,start,busy)", tag),
              int'({bus.wr_ack, bus.wr_err, bus.draw_start, bus.busy}),
              int'({m_ack, m_err, m_start, m_out}));
        check($sformatf("%s dirty_count", tag), int'(bus.dirty_count), popcount());
        check($sformatf("%s draw(row,col,data)", tag),
              int'(bus.draw_row) * 256 + int'(bus.draw_col) * 16 + int'(bus.draw_data),
              m_row * 256 + m_col * 16 + m_data);
    endtask

    task automatic tick();
        bit valid;
        int idx;
        if (rand_done) bus.draw_done = ($urandom_range(0, 3) == 0);
        else           bus.draw_done = m_out && (m_since >= rend_lat);
        valid = (int'(bus.wr_row) < N) && (int'(bus.wr_col) < N) && (int'(bus.wr_data) <= 9);
        idx   = int'(bus.wr_row) * N + int'(bus.wr_col);
        m_ack   = bus.wr_en && valid;
        m_err   = bus.wr_en && !valid;
        m_start = 1'b0;
        if (!m_out) begin
            if (m_dirty[m_ptr]) begin
                m_row = m_ptr / N; m_col = m_ptr % N; m_data = m_cell[m_ptr];
                m_dirty[m_ptr] = 1'b0;
                m_out = 1'b1; m_start = 1'b1; m_since = 0;
            end else begin
                m_ptr = (m_ptr + 1) % C;
            end
        end else if (bus.draw_done) begin
            m_out = 1'b0;
            m_ptr = (m_ptr + 1) % C;
        end else begin
            m_since++;
        end
        if (m_ack) begin
            m_cell[idx]  = int'(bus.wr_data);
            m_dirty[idx] = 1'b1;
        end
        if (bus.full_redraw) for (int i = 0; i < C; i++) m_dirty[i] = 1'b1;
        @(posedge clk);
        #1;
        cyc++;
        check_outputs($sformatf("cyc%0d", cyc));
        if (bus.draw_start) drawq.push_back('{int'(bus.draw_row), int'(bus.draw_col), int'(bus.draw_data)});
        bus.wr_en       = 1'b0;
        bus.full_redraw = 1'b0;
    endtask

    task automatic write(input int r, input int c, input int d);
        bus.wr_en   = 1'b1;
        bus.wr_row  = 4'(r);
        bus.wr_col  = 4'(c);
        bus.wr_data = 4'(d);
    endtask

    task automatic settle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic run_until(input int n, input int budget, input string name);
        int k = 0;
        while (drawq.size() < n && k < budget) begin
            tick();
            k++;
        end
        check(name, drawq.size(), n);
    endtask

    task automatic wait_draw_at(input int r, input int c, input string name);
        int found = 0;
        for (int k = 0; k < 4 * C && found == 0; k++) begin
            tick();
            if (bus.draw_start && int'(bus.draw_row) == r && int'(bus.draw_col) == c) found = 1;
        end
        check(name, found, 1);
    endtask

    initial begin
        wvec_t tbl[8];
        int    seen, nz;
        bit    hitmap[C];

        tbl[0] = '{4'd4,  4'd7,  4'd5,  1'b1, 1'b0};
        tbl[1] = '{4'd9,  4'd0,  4'd1,  1'b0, 1'b1};
        tbl[2] = '{4'd0,  4'd9,  4'd1,  1'b0, 1'b1};
        tbl[3] = '{4'd0,  4'd0,  4'd12, 1'b0, 1'b1};
        tbl[4] = '{4'd8,  4'd8,  4'd9,  1'b1, 1'b0};
        tbl[5] = '{4'd15, 4'd15, 4'd0,  1'b0, 1'b1};
        tbl[6] = '{4'd3,  4'd3,  4'd10, 1'b0, 1'b1};
        tbl[7] = '{4'd8,  4'd0,  4'd0,  1'b1, 1'b0};

        rst = 1'b1;
        bus.wr_en = 1'b0; bus.wr_row = '0; bus.wr_col = '0; bus.wr_data = '0;
        bus.full_redraw = 1'b0; bus.draw_done = 1'b0;
        rend_lat = 3; rand_done = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outputs("reset");
        check("reset dirty_count=C", int'(bus.dirty_count), C);
        rst = 1'b0;

        // Power-up sweep: every cell once, row-major, all empty.
        run_until(C, C * 8 + 100, "boot draw count");
        for (int i = 0; i < drawq.size(); i++)
            check($sformatf("boot draw %0d", i),
                  drawq[i].r * 256 + drawq[i].c * 16 + drawq[i].d, (i / N) * 256 + (i % N) * 16);
        settle(C + 10);
        check("boot no extra draws", drawq.size(), C);
        check("boot busy low", int'(bus.busy), 0);
        check("boot count zero", int'(bus.dirty_count), 0);

        // Single write is drawn exactly once.
        drawq.delete();
        write(4, 7, 5);
        tick();
        check("w47 ack", int'(bus.wr_ack), 1);
        check("w47 count one", int'(bus.dirty_count), 1);
        run_until(1, C + 10, "w47 draw seen");
        settle(C + 10);
        check("w47 single draw", drawq.size(), 1);
        if (drawq.size() > 0) check("w47 draw", drawq[0].r * 256 + drawq[0].c * 16 + drawq[0].d, 4 * 256 + 7 * 16 + 5);
        check("w47 count back to zero", int'(bus.dirty_count), 0);

        // Rewrite of the cell under draw: snapshot kept, cell redrawn afterwards.
        drawq.delete();
        rend_lat = 1000;
        write(2, 2, 3);
        tick();
        wait_draw_at(2, 2, "c22 first draw issued");
        tick();
        check("c22 in wait busy", int'(bus.busy), 1);
        write(2, 2, 9);
        tick();
        check("c22 snapshot held", int'(bus.draw_data), 3);
        rend_lat = 0;
        settle(2 * C + 20);
        check("c22 draw count", drawq.size(), 2);
        if (drawq.size() == 2) begin
            check("c22 first", drawq[0].r * 256 + drawq[0].c * 16 + drawq[0].d, 2 * 256 + 2 * 16 + 3);
            check("c22 second", drawq[1].r * 256 + drawq[1].c * 16 + drawq[1].d, 2 * 256 + 2 * 16 + 9);
        end

        // Rejected writes leave the board clean.
        drawq.delete();
        write(9, 0, 1);
        tick();
        check("row9 err", int'(bus.wr_err), 1);
        write(0, 0, 12);
        tick();
        check("data12 err", int'(bus.wr_err), 1);
        check("err count unchanged", int'(bus.dirty_count), 0);
        settle(C + 10);
        check("err no draws", drawq.size(), 0);

        for (int i = 0; i < 8; i++) begin
            write(int'(tbl[i].row), int'(tbl[i].col), int'(tbl[i].data));
            tick();
            check($sformatf("tbl%0d ack", i), int'(bus.wr_ack), int'(tbl[i].ack));
            check($sformatf("tbl%0d err", i), int'(bus.wr_err), int'(tbl[i].err));
        end
        settle(2 * C + 20);

        // full_redraw together with a write.
        drawq.delete();
        bus.full_redraw = 1'b1;
        write(0, 3, 1);
        tick();
        check("redraw count=C", int'(bus.dirty_count), C);
        run_until(C, C * 4 + 50, "redraw draw count");
        settle(C + 10);
        check("redraw no extra", drawq.size(), C);
        for (int i = 0; i < C; i++) hitmap[i] = 1'b0;
        seen = 0;
        foreach (drawq[i]) begin
            if (!hitmap[drawq[i].r * N + drawq[i].c]) seen++;
            hitmap[drawq[i].r * N + drawq[i].c] = 1'b1;
            if (drawq[i].r == 0 && drawq[i].c == 3) check("redraw (0,3) data", drawq[i].d, 1);
            if (drawq[i].r == 0 && drawq[i].c == 0) check("redraw (0,0) untouched by err", drawq[i].d, 0);
            if (drawq[i].r == 4 && drawq[i].c == 7) check("redraw (4,7) data", drawq[i].d, 5);
        end
        check("redraw distinct cells", seen, C);

        // Asynchronous reset while waiting on the renderer.
        rend_lat = 1000;
        write(5, 5, 2);
        tick();
        wait_draw_at(5, 5, "c55 draw issued");
        tick();
        check("c55 in wait", int'(bus.busy), 1);
        rst = 1'b1;
        #1;
        check("async rst draw_start", int'(bus.draw_start), 0);
        check("async rst busy", int'(bus.busy), 0);
        check("async rst count", int'(bus.dirty_count), C);
        check("async rst draw_data", int'(bus.draw_data), 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        drawq.delete();
        rend_lat = 0;
        run_until(C, C * 3 + 50, "post-rst draw count");
        if (drawq.size() > 0) check("post-rst first draw", drawq[0].r * 256 + drawq[0].c * 16 + drawq[0].d, 0);
        nz = 0;
        foreach (drawq[i]) if (drawq[i].d != 0) nz++;
        check("post-rst data all zero", nz, 0);

        // Random traffic with a random renderer.
        rand_done = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0)
                write(int'($urandom_range(0, 10)), int'($urandom_range(0, 10)), int'($urandom_range(0, 11)));
            if ($urandom_range(0, 99) == 0) bus.full_redraw = 1'b1;
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
